// File: rtl/image_pkg.sv
// Shared pixel widths, rounding constants and counter sizing for the
// image pipeline blocks.
package image_pkg;

  localparam int PIXEL_W    = 8;
  localparam int PAIR_W     = PIXEL_W + 1;
  localparam int SUM_W      = 10;
  localparam int ROUND_BIAS = 2;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [PAIR_W-1:0]  pair_sum_t;
  typedef logic [SUM_W-1:0]   block_sum_t;

  // A counter over n values needs at least one bit, even when n is 1.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/partial_sum_line_buffer.sv
// Holds one horizontal pair sum per output column between the even row
// that produces it and the odd row that consumes it.
module partial_sum_line_buffer
  import image_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = count_width(DEPTH)
) (
  input  logic              clock,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  pair_sum_t         write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output pair_sum_t         read_data
);

  pair_sum_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/block_average_downscale.sv
// Streaming 2x zoom-out: emits the rounded mean of every 2x2 input block
// in raster order over valid/ready streams.
module block_average_downscale
  import image_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int IN_HEIGHT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int COL_W     = count_width(IN_WIDTH);
  localparam int ROW_W     = count_width(IN_HEIGHT);
  localparam int LB_AW     = count_width(OUT_WIDTH);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  pixel_t           pair;

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             emit;
  logic [LB_AW-1:0] lb_addr;
  logic             lb_write_en;
  pair_sum_t        lb_write_data;
  pair_sum_t        lb_read_data;
  block_sum_t       block_sum;
  logic [SUM_W:0]   rounded;
  pixel_t           block_avg;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_W'(IN_WIDTH - 1));
  assign row_last = (row == ROW_W'(IN_HEIGHT - 1));

  // Row/column parity alone decides what each consumed pixel contributes.
  assign emit          = accept && col[0] && row[0];
  assign lb_write_en   = accept && col[0] && !row[0];
  assign lb_addr       = LB_AW'(col >> 1);
  assign lb_write_data = PAIR_W'(pair) + PAIR_W'(in_pixel);

  assign block_sum = SUM_W'(lb_read_data) + SUM_W'(pair) + SUM_W'(in_pixel);
  assign rounded   = (SUM_W + 1)'(block_sum) + (SUM_W + 1)'(ROUND_BIAS);
  assign block_avg = PIXEL_W'(rounded >> 2);

  partial_sum_line_buffer #(
    .DEPTH  (OUT_WIDTH),
    .ADDR_W (LB_AW)
  ) u_line_buffer (
    .clock      (clock),
    .write_en   (lb_write_en),
    .write_addr (lb_addr),
    .write_data (lb_write_data),
    .read_addr  (lb_addr),
    .read_data  (lb_read_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pair <= '0;
    end else if (accept && !col[0]) begin
      pair <= in_pixel;
    end
  end

  // A fresh load wins over a drain, so back-to-back outputs never drop valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_pixel <= block_avg;
      out_last  <= row_last && col_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_average_downscale.sv
// Self-checking bench: table-driven rounding vectors, hand-written stall,
// reset and frame sequences, and randomized frames against a block model.
module tb_block_average_downscale;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } out_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] expected;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] w_in_pixel;
  logic       w_in_valid;
  logic       w_in_ready;
  logic [7:0] w_out_pixel;
  logic       w_out_valid;
  logic       w_out_ready;
  logic       w_out_last;

  int         checks;
  int         failures;
  int         xfer_count;
  bit         rand_ready;
  int         model_idx;
  int         img [H][W];
  out_t       exp_q [$];
  logic [7:0] got_q [$];
  vec_t       vecs [8];

  block_average_downscale #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  block_average_downscale #(
    .IN_WIDTH  (8),
    .IN_HEIGHT (2)
  ) u_dut_wide (
    .clock     (clock),
    .reset     (reset),
    .in_pixel  (w_in_pixel),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .out_pixel (w_out_pixel),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_last  (w_out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference: store the frame by position; a block completes at its
  // bottom-right pixel and its value is the rounded mean of four pixels.
  task automatic model_consume(input int p, output bit done, output int avg,
                               output bit last);
    int r;
    int c;
    r = model_idx / W;
    c = model_idx % W;
    img[r][c] = p;
    done = (r % 2 == 1) && (c % 2 == 1);
    avg  = 0;
    if (done) avg = (img[r-1][c-1] + img[r-1][c] + img[r][c-1] + p + 2) / 4;
    last = (model_idx == W * H - 1);
    model_idx = (model_idx + 1) % (W * H);
  endtask

  task automatic cycle(output bit consumed);
    bit   xfer;
    bit   done;
    bit   last;
    int   avg;
    out_t e;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    consumed = in_valid && in_ready;
    xfer     = out_valid && out_ready;
    if (xfer) begin
      xfer_count++;
      got_q.push_back(out_pixel);
      if (exp_q.size() == 0) begin
        check_output("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("stream_pixel", out_pixel, e.pix);
        check_output("stream_last", out_last, e.last);
      end
    end
    done = 1'b0;
    if (consumed) model_consume(in_pixel, done, avg, last);
    @(posedge clock);
    @(negedge clock);
    if (done) begin
      check_output("latency_valid", out_valid, 1);
      check_output("latency_pixel", out_pixel, avg);
      check_output("latency_last", out_last, last);
      exp_q.push_back('{pix: 8'(avg), last: last});
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] p, input int max_gap);
    bit consumed;
    int tries;
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    in_valid = 1'b0;
    repeat (gap) cycle(consumed);
    in_valid = 1'b1;
    in_pixel = p;
    tries    = 0;
    consumed = 1'b0;
    while (!consumed && tries < 200) begin
      cycle(consumed);
      tries++;
    end
    if (!consumed) check_output("input_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit consumed;
    int tries;
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    tries      = 0;
    while (out_valid && tries < 200) begin
      cycle(consumed);
      tries++;
    end
    check_output("drain_done", out_valid, 0);
    check_output("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    w_in_valid = 1'b0;
    reset      = 1'b0;
    #1;
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_out_pixel", out_pixel, 0);
    check_output("reset_out_last", out_last, 0);
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    model_idx = 0;
    exp_q.delete();
  endtask

  task automatic send_frame_1_to_16(input int max_gap);
    for (int i = 1; i <= 16; i++) apply_stimulus(8'(i), max_gap);
  endtask

  task automatic check_got(input string name, input int e0, input int e1,
                           input int e2, input int e3);
    int want [4];
    want = '{e0, e1, e2, e3};
    check_output({name, "_count"}, got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check_output({name, "_value"}, got_q[k], want[k]);
  endtask

  initial begin
    bit         consumed;
    int         start_xfers;
    int         r;
    int         c;
    logic [7:0] p;
    logic [7:0] wide_pix [$];
    logic       wide_last [$];
    int         wide_exp [4];

    checks      = 0;
    failures    = 0;
    xfer_count  = 0;
    rand_ready  = 1'b0;
    model_idx   = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_pixel    = '0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_pixel  = '0;
    w_out_ready = 1'b1;

    vecs[0] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd1,   expected: 8'd0};
    vecs[1] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd2,   expected: 8'd1};
    vecs[2] = '{a: 8'd255, b: 8'd255, c: 8'd255, d: 8'd255, expected: 8'd255};
    vecs[3] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   d: 8'd4,   expected: 8'd3};
    vecs[4] = '{a: 8'd0,   b: 8'd1,   c: 8'd1,   d: 8'd0,   expected: 8'd1};
    vecs[5] = '{a: 8'd3,   b: 8'd3,   c: 8'd3,   d: 8'd2,   expected: 8'd3};
    vecs[6] = '{a: 8'd128, b: 8'd127, c: 8'd128, d: 8'd127, expected: 8'd128};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   c: 8'd1,   d: 8'd0,   expected: 8'd0};

    @(negedge clock);
    do_reset();
    #1;
    check_output("idle_in_ready", in_ready, 1);
    @(negedge clock);

    $display("[TB] basic 1..16 frame");
    got_q.delete();
    send_frame_1_to_16(0);
    drain();
    check_got("basic", 4, 6, 12, 14);

    $display("[TB] rounding table");
    foreach (vecs[v]) begin
      got_q.delete();
      for (int i = 0; i < W * H; i++) begin
        r = i / W;
        c = i % W;
        case ({r[0], c[0]})
          2'b00:   p = vecs[v].a;
          2'b01:   p = vecs[v].b;
          2'b10:   p = vecs[v].c;
          default: p = vecs[v].d;
        endcase
        apply_stimulus(p, 0);
      end
      drain();
      check_got("round_vec", vecs[v].expected, vecs[v].expected,
                vecs[v].expected, vecs[v].expected);
    end

    $display("[TB] output stall");
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) apply_stimulus(8'(i), 0);
    in_valid = 1'b1;
    in_pixel = 8'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_output("stall_out_valid", out_valid, 1);
      check_output("stall_out_pixel", out_pixel, 4);
      check_output("stall_in_ready", in_ready, 0);
      @(posedge clock);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 7; i <= 16; i++) apply_stimulus(8'(i), 0);
    drain();
    check_got("stall", 4, 6, 12, 14);

    $display("[TB] two frames with gaps");
    got_q.delete();
    start_xfers = xfer_count;
    send_frame_1_to_16(2);
    for (int i = 0; i < 16; i++) apply_stimulus(8'd200, 2);
    drain();
    check_output("two_frame_count", xfer_count - start_xfers, 8);
    for (int k = 4; k < 8 && k < got_q.size(); k++)
      check_output("two_frame_200", got_q[k], 200);

    $display("[TB] reset mid-frame");
    for (int i = 1; i <= 6; i++) apply_stimulus(8'(i), 0);
    @(negedge clock);
    do_reset();
    @(negedge clock);
    got_q.delete();
    send_frame_1_to_16(0);
    drain();
    check_got("post_reset", 4, 6, 12, 14);

    $display("[TB] random frames with random backpressure");
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W * H; i++) apply_stimulus(8'($urandom_range(0, 255)), 2);
    drain();

    $display("[TB] 8x2 frame");
    wide_exp    = '{5, 7, 9, 11};
    w_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w_in_valid = (i < 16);
      w_in_pixel = 8'(i);
      @(posedge clock);
      @(negedge clock);
      if (w_out_valid) begin
        wide_pix.push_back(w_out_pixel);
        wide_last.push_back(w_out_last);
      end
    end
    w_in_valid = 1'b0;
    check_output("wide_count", wide_pix.size(), 4);
    for (int k = 0; k < 4 && k < wide_pix.size(); k++) begin
      check_output("wide_pixel", wide_pix[k], wide_exp[k]);
      check_output("wide_last", wide_last[k], (k == 3) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
